// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the sequential W x W multiplier (mul16_seq):
//   - state_t     : sequencer states IDLE / LOAD / WAIT / DONE
//   - PARTIALS    : number of H x H partial products per full product
//   - MUL_N       : Booth multiplier width for the default W = 16 build
//   - LATENCY     : accept-to-out_valid cycles for the default W = 16 build
//   - shift()     : left shift applied to partial product k when accumulated
// -----------------------------------------------------------------------------
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int W_DEFAULT = 16;
    localparam int H_DEFAULT = W_DEFAULT / 2;
    localparam int PARTIALS  = 4;
    localparam int MUL_N     = H_DEFAULT + 1;
    localparam int LATENCY   = PARTIALS * (H_DEFAULT + 3) + 1;

    // Partial order is (lo,lo) (hi,lo) (lo,hi) (hi,hi); cross terms sit at H.
    function automatic int shift(input logic [1:0] k, input int h);
        int amt;
        case (k)
            2'd0:    amt = 0;
            2'd1:    amt = h;
            2'd2:    amt = h;
            2'd3:    amt = 2 * h;
            default: amt = 0;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/mul16_seq_booth.sv
// -----------------------------------------------------------------------------
// Booth_Multiplier_1xA
// Radix-2 Booth multiplier retiring one multiplier bit per clock.
// Ports:
//   clk   in   clock
//   Rst   in   synchronous active-high reset
//   Ld    in   load M and R and start a multiplication
//   M     in   N-bit signed multiplicand
//   R     in   N-bit signed multiplier
//   Valid out  single-cycle pulse, N+1 cycles after the Ld cycle
//   P     out  2N-bit signed product, held until the next result
// The partial remainder is kept one bit wider than M so that adding or
// subtracting the most negative multiplicand cannot overflow.
// -----------------------------------------------------------------------------
module Booth_Multiplier_1xA #(
    parameter int N = 9
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             Ld,
    input  logic [N-1:0]     M,
    input  logic [N-1:0]     R,
    output logic             Valid,
    output logic [2*N-1:0]   P
);

    localparam int CW = $clog2(N + 1);

    logic [N:0]     acc_r;
    logic [N:0]     m_r;
    logic [N-1:0]   q_r;
    logic           q1_r;
    logic [CW-1:0]  cnt_r;
    logic           valid_r;
    logic [2*N-1:0] p_r;

    logic [N:0]     sum_s;
    logic [N:0]     acc_nx_s;
    logic [N-1:0]   q_nx_s;

    // Booth recode of {q0, q-1}, then arithmetic shift of {acc, q} right by one.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
        acc_nx_s = {sum_s[N], sum_s[N:1]};
        q_nx_s   = {sum_s[0], q_r[N-1:1]};
    end

    // Iteration registers: load on Ld, step while the counter is non-zero.
    always_ff @(posedge clk) begin
        if (Rst) begin
            acc_r   <= '0;
            m_r     <= '0;
            q_r     <= '0;
            q1_r    <= 1'b0;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            p_r     <= '0;
        end else if (Ld) begin
            acc_r   <= '0;
            m_r     <= {M[N-1], M};
            q_r     <= R;
            q1_r    <= 1'b0;
            cnt_r   <= CW'(N);
            valid_r <= 1'b0;
        end else if (cnt_r != '0) begin
            acc_r <= acc_nx_s;
            q_r   <= q_nx_s;
            q1_r  <= q_r[0];
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                valid_r <= 1'b1;
                p_r     <= {acc_nx_s[N-1:0], q_nx_s};
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign Valid = valid_r;
    assign P     = p_r;

endmodule

// File: rtl/mul16_seq.sv
// -----------------------------------------------------------------------------
// mul16_seq
// Unsigned W x W multiplier built from four H x H partial products issued
// through one Booth_Multiplier_1xA (width H+1, operands zero-extended so the
// signed product equals the unsigned one). Products are shifted and summed
// into a 2W+1-bit accumulator.
// Ports:
//   clk        in   clock
//   Rst        in   synchronous active-high reset (also resets the multiplier)
//   in_valid   in   operands a, b present
//   in_ready   out  operands accepted (IDLE only)
//   a, b       in   W-bit unsigned operands
//   out_valid  out  p holds a finished product (DONE)
//   out_ready  in   consumer takes p
//   p          out  2W-bit product, held until the next product completes
//   busy       out  operation in progress (LOAD, WAIT, DONE)
// -----------------------------------------------------------------------------
module mul16_seq
    import mul_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    localparam int H     = W / 2;
    localparam int N     = H + 1;
    localparam int ACC_W = 2 * W + 1;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [1:0]     k_r;
    logic [ACC_W-1:0] acc_r;
    logic [2*W-1:0] p_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;

    logic [H-1:0]   half_a_s;
    logic [H-1:0]   half_b_s;
    logic           mul_ld_s;
    logic [N-1:0]   mul_m_s;
    logic [N-1:0]   mul_r_s;
    logic           mul_valid_s;
    logic [2*N-1:0] mul_p_s;
    logic [ACC_W-1:0] partial_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic           unused_s;

    // k bit 0 picks the half of a, k bit 1 picks the half of b.
    always_comb begin
        half_a_s  = k_r[0] ? a_r[W-1:H] : a_r[H-1:0];
        half_b_s  = k_r[1] ? b_r[W-1:H] : b_r[H-1:0];
        mul_m_s   = {1'b0, half_a_s};
        mul_r_s   = {1'b0, half_b_s};
        partial_s = ACC_W'(mul_p_s[2*H-1:0]) << shift(k_r, H);
        acc_sum_s = acc_r + partial_s;
    end

    // The top two product bits are always zero for zero-extended operands.
    assign unused_s = ^mul_p_s[2*N-1:2*H];

    Booth_Multiplier_1xA #(
        .N (N)
    ) u_booth (
        .clk   (clk),
        .Rst   (Rst),
        .Ld    (mul_ld_s),
        .M     (mul_m_s),
        .R     (mul_r_s),
        .Valid (mul_valid_s),
        .P     (mul_p_s)
    );

    // Next-state and multiplier load strobe.
    always_comb begin
        state_s  = state_r;
        mul_ld_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                mul_ld_s = 1'b1;
                state_s  = WAIT;
            end
            WAIT: begin
                if (mul_valid_s) begin
                    if (k_r == 2'd3) begin
                        state_s = DONE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Operand capture, partial index, accumulator and held product.
    always_ff @(posedge clk) begin
        if (Rst) begin
            a_r   <= '0;
            b_r   <= '0;
            k_r   <= 2'd0;
            acc_r <= '0;
            p_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        k_r   <= 2'd0;
                        acc_r <= '0;
                    end
                end
                WAIT: begin
                    if (mul_valid_s) begin
                        acc_r <= acc_sum_s;
                        if (k_r == 2'd3) begin
                            p_r <= acc_sum_s[2*W-1:0];
                        end else begin
                            k_r <= k_r + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = p_r;

endmodule

// File: tb/tb_mul16_seq.sv
// -----------------------------------------------------------------------------
// tb_mul16_seq
// Self-checking bench for mul16_seq (W = 16). Expected products come from
// plain a*b arithmetic; expected timing from the H+3-cycles-per-partial rule.
// -----------------------------------------------------------------------------
module tb_mul16_seq;

    localparam int W       = 16;
    localparam int H       = W / 2;
    localparam int LAT     = 4 * (H + 3) + 1;
    localparam int SPACING = LAT + 1;
    localparam int BOUND   = 200;

    logic           clk = 1'b0;
    logic           Rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul16_seq #(.W(W)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present operands for one cycle.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok, output int acc_cyc);
        int t;
        t = 0;
        while (!in_ready && t < BOUND) begin
            step();
            t++;
        end
        ok       = in_ready;
        acc_cyc  = cyc;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles counted from the accept cycle until out_valid is seen.
    task automatic wait_out(output int n, output bit ok);
        n = 1;
        while (!out_valid && n < BOUND) begin
            step();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 32'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b p=%h busy=%b, required 1 0 00000000 0",
                     in_ready, out_valid, p, busy);
        end
        Rst = 1'b0;
        step();
    endtask

    task automatic test_product(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        int n;
        int ac;
        logic [2*W-1:0] exp;
        exp = model(x, y);
        accept(x, y, ok, ac);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready stayed 0, required 1", name);
        end
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: busy=%b in_ready=%b, required 1 0", name, busy, in_ready);
        end
        wait_out(n, ok);
        n_checks++;
        if (!ok || n != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid after %0d cycles, required %0d", name, n, LAT);
        end
        n_checks++;
        if (p !== exp) begin
            n_fail++;
            $display("FAIL %s_p: got %h, required %h", name, p, exp);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== exp) begin
            n_fail++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b p=%h, required 1 0 %h",
                     name, in_ready, out_valid, p, exp);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int ac;
        int bad;
        logic [2*W-1:0] exp;
        exp = model(16'h00AB, 16'h0C0D);
        out_ready = 1'b0;
        accept(16'h00AB, 16'h0C0D, ok, ac);
        wait_out(n, ok);
        n_checks++;
        if (!ok || p !== exp) begin
            n_fail++;
            $display("FAIL bp_first: out_valid=%b p=%h, required 1 %h", out_valid, p, exp);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            a = 16'hDEAD;
            b = 16'hBEEF;
            if (p !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d cycles with p/out_valid/in_ready disturbed, required 0", bad);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== exp) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b p=%h, required 1 0 0 %h",
                     in_ready, out_valid, busy, p, exp);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_capture: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int ac;
        int seen;
        accept(16'hFFFF, 16'hFFFF, ok, ac);
        repeat (19) step();
        Rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 32'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b p=%h busy=%b, required 1 0 00000000 0",
                     in_ready, out_valid, p, busy);
        end
        Rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with out_valid/busy after abort, required 0", seen);
        end
        test_product("after_abort", 16'd3, 16'd5);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int ac;
        int prev_ac;
        logic [W-1:0] x;
        logic [W-1:0] y;
        out_ready = 1'b1;
        prev_ac = -1;
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            accept(x, y, ok, ac);
            if (prev_ac >= 0) begin
                n_checks++;
                if (ac - prev_ac != SPACING) begin
                    n_fail++;
                    $display("FAIL b2b_spacing_%0d: %0d cycles, required %0d", i, ac - prev_ac, SPACING);
                end
            end
            prev_ac = ac;
            wait_out(n, ok);
            n_checks++;
            if (!ok || p !== model(x, y)) begin
                n_fail++;
                $display("FAIL b2b_p_%0d: got %h valid=%b, required %h", i, p, out_valid, model(x, y));
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            test_product("random", W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_product("basic", 16'h1234, 16'h5678);
        test_product("max", 16'hFFFF, 16'hFFFF);
        test_product("msb", 16'h8000, 16'h0002);
        test_product("zero", 16'h0000, 16'hBEEF);
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
